// File: rtl/ppu_vram_if.sv
// CPU-side VRAM port: PPUADDR double-write latch and PPUDATA buffered read/write
// sequencing against a one-clock-latency synchronous VRAM.
module ppu_vram_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            ri_sel,
    input  logic                  ri_req,
    input  logic                  ri_wr,
    input  logic [DATA_WIDTH-1:0] ri_din,
    input  logic                  inc32,
    input  logic                  clr_latch,
    output logic [DATA_WIDTH-1:0] ri_dout,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] vram_a,
    output logic                  vram_wr,
    output logic [DATA_WIDTH-1:0] vram_dout,
    input  logic [DATA_WIDTH-1:0] vram_din
);

    localparam int HI_W = ADDR_WIDTH - DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, WR, RD_ADDR, RD_CAP} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   v;
    logic [HI_W-1:0]         t_hi;
    logic                    w;
    logic [DATA_WIDTH-1:0]   rd_buf;

    logic                    addr_wr, data_wr, data_rd;
    logic                    load_v, do_inc;
    logic [ADDR_WIDTH-1:0]   inc_amt;

    assign addr_wr = ri_req &  ri_wr & (ri_sel == 3'd6);
    assign data_wr = ri_req &  ri_wr & (ri_sel == 3'd7);
    assign data_rd = ri_req & ~ri_wr & (ri_sel == 3'd7);

    // clr_latch forces a coincident PPUADDR write down the first-write path
    assign load_v  = addr_wr & w & ~clr_latch;
    assign do_inc  = (state == WR) || (state == RD_CAP);
    assign inc_amt = inc32 ? ADDR_WIDTH'(32) : ADDR_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (data_wr)      state_nxt = WR;
                else if (data_rd) state_nxt = RD_ADDR;
            end
            WR:      state_nxt = IDLE;
            RD_ADDR: state_nxt = RD_CAP;
            RD_CAP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        vram_wr = (state == WR);
        busy    = (state != IDLE);
        vram_a  = v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v    <= '0;
            t_hi <= '0;
            w    <= 1'b0;
        end else begin
            if (addr_wr && !load_v) begin
                t_hi <= ri_din[HI_W-1:0];
                w    <= 1'b1;
            end else if (load_v || clr_latch) begin
                w    <= 1'b0;
            end

            // A completed PPUADDR load overrides the post-access increment
            if (load_v) begin
                v <= {t_hi, ri_din};
            end else if (do_inc) begin
                v <= v + inc_amt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_dout <= '0;
            ri_dout   <= '0;
            rd_buf    <= '0;
        end else begin
            if (state == IDLE && data_wr) vram_dout <= ri_din;
            // The CPU sees the previous buffer contents; the fresh byte lands in rd_buf
            if (state == IDLE && data_rd) ri_dout <= rd_buf;
            if (state == RD_CAP)          rd_buf  <= vram_din;
        end
    end

endmodule

// File: tb/tb_ppu_vram_if.sv
// Directed bench for ppu_vram_if with a behavioural one-clock-latency VRAM.
module tb_ppu_vram_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ri_sel;
    logic        ri_req;
    logic        ri_wr;
    logic [7:0]  ri_din;
    logic        inc32;
    logic        clr_latch;
    logic [7:0]  ri_dout;
    logic        busy;
    logic [13:0] vram_a;
    logic        vram_wr;
    logic [7:0]  vram_dout;
    logic [7:0]  vram_din;

    logic [7:0]  mem [0:16383];

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (vram_wr) mem[vram_a] <= vram_dout;
        vram_din <= mem[vram_a];
    end

    ppu_vram_if #(.ADDR_WIDTH(14), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ri_sel    (ri_sel),
        .ri_req    (ri_req),
        .ri_wr     (ri_wr),
        .ri_din    (ri_din),
        .inc32     (inc32),
        .clr_latch (clr_latch),
        .ri_dout   (ri_dout),
        .busy      (busy),
        .vram_a    (vram_a),
        .vram_wr   (vram_wr),
        .vram_dout (vram_dout),
        .vram_din  (vram_din)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reg_access(input logic [2:0] sel, input logic wr, input logic [7:0] d);
        ri_sel = sel;
        ri_wr  = wr;
        ri_din = d;
        ri_req = 1'b1;
        tick();
        ri_req = 1'b0;
        ri_wr  = 1'b0;
    endtask

    task automatic set_addr(input logic [7:0] hi, input logic [7:0] lo);
        reg_access(3'd6, 1'b1, hi);
        reg_access(3'd6, 1'b1, lo);
    endtask

    initial begin
        rst_n = 1'b0; ri_sel = 3'd0; ri_req = 1'b0; ri_wr = 1'b0;
        ri_din = 8'h00; inc32 = 1'b0; clr_latch = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_ri_dout", 32'(ri_dout), 32'h00);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_vram_a", 32'(vram_a), 32'h0000);
        check("rst_vram_wr", 32'(vram_wr), 32'h0);
        check("rst_vram_dout", 32'(vram_dout), 32'h00);

        // Basic write
        set_addr(8'h21, 8'h08);
        check("addr_2108", 32'(vram_a), 32'h2108);
        reg_access(3'd7, 1'b1, 8'h5A);
        check("wr_pulse", 32'(vram_wr), 32'h1);
        check("wr_addr", 32'(vram_a), 32'h2108);
        check("wr_data", 32'(vram_dout), 32'h5A);
        check("wr_busy", 32'(busy), 32'h1);
        tick();
        check("wr_pulse_end", 32'(vram_wr), 32'h0);
        check("wr_inc", 32'(vram_a), 32'h2109);
        check("wr_idle", 32'(busy), 32'h0);

        // Preload 0x2000..0x2002 through the port
        set_addr(8'h20, 8'h00);
        reg_access(3'd7, 1'b1, 8'h11); tick();
        reg_access(3'd7, 1'b1, 8'h22); tick();
        reg_access(3'd7, 1'b1, 8'h33); tick();
        check("preload_v", 32'(vram_a), 32'h2003);

        // Buffered reads
        set_addr(8'h20, 8'h00);
        reg_access(3'd7, 1'b0, 8'h00);
        check("rd1_stale", 32'(ri_dout), 32'h00);
        check("rd1_busy_a", 32'(busy), 32'h1);
        tick();
        check("rd1_busy_b", 32'(busy), 32'h1);
        tick();
        check("rd1_done", 32'(busy), 32'h0);
        check("rd1_inc", 32'(vram_a), 32'h2001);
        reg_access(3'd7, 1'b0, 8'h00); tick(); tick();
        check("rd2_data", 32'(ri_dout), 32'h11);
        reg_access(3'd7, 1'b0, 8'h00); tick(); tick();
        check("rd3_data", 32'(ri_dout), 32'h22);
        check("rd3_v", 32'(vram_a), 32'h2003);

        // Wrap on +32 write, then on +1 read
        inc32 = 1'b1;
        set_addr(8'h3F, 8'hE0);
        reg_access(3'd7, 1'b1, 8'h77); tick();
        check("wrap32", 32'(vram_a), 32'h0000);
        check("dout_hold_wr", 32'(ri_dout), 32'h22);
        inc32 = 1'b0;
        set_addr(8'h3F, 8'hFF);
        reg_access(3'd7, 1'b0, 8'h00);
        check("rd4_buf", 32'(ri_dout), 32'h33);
        tick(); tick();
        check("wrap1", 32'(vram_a), 32'h0000);

        // Other register indices are ignored
        reg_access(3'd5, 1'b1, 8'h12);
        reg_access(3'd2, 1'b0, 8'h00);
        check("ign_v", 32'(vram_a), 32'h0000);
        check("ign_dout", 32'(ri_dout), 32'h33);
        check("ign_busy", 32'(busy), 32'h0);

        // clr_latch discards a half-written address
        reg_access(3'd6, 1'b1, 8'h23);
        clr_latch = 1'b1; tick(); clr_latch = 1'b0;
        set_addr(8'h24, 8'h00);
        check("clr_latch_v", 32'(vram_a), 32'h2400);

        // Back-to-back write: second one dropped
        reg_access(3'd7, 1'b1, 8'hA5);
        check("b2b_pulse", 32'(vram_wr), 32'h1);
        reg_access(3'd7, 1'b1, 8'h3C);
        check("b2b_no_pulse", 32'(vram_wr), 32'h0);
        check("b2b_v", 32'(vram_a), 32'h2401);
        check("b2b_idle", 32'(busy), 32'h0);
        tick();
        check("b2b_no_pulse2", 32'(vram_wr), 32'h0);
        check("b2b_v2", 32'(vram_a), 32'h2401);
        check("b2b_dout", 32'(vram_dout), 32'hA5);

        // Reset in the middle of a write
        reg_access(3'd7, 1'b1, 8'h99);
        check("rstwr_pulse", 32'(vram_wr), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rstwr_async", 32'(vram_wr), 32'h0);
        check("rstwr_busy", 32'(busy), 32'h0);
        check("rstwr_v", 32'(vram_a), 32'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        check("rstwr_noinc", 32'(vram_a), 32'h0000);
        check("rstwr_dout", 32'(vram_dout), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
